// File: rtl/fifo_param_sync_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
// Holds the error-code bit positions and the pointer wrap helper.
package fifo_param_sync_pkg;

   localparam int ERR_OVF = 0;
   localparam int ERR_UDF = 1;
   localparam int ERR_W   = 2;

   typedef logic [ERR_W-1:0] err_code_t;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// MAIN_SIZE x DATA_SIZE storage with one synchronous write port and one registered read port.
// A same-cycle read and write to one address returns the old word.
module fifo_mem_dp #(
   parameter int DATA_SIZE = 8,
   parameter int MAIN_SIZE = 8,
   parameter int ADDR_W    = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [DATA_SIZE-1:0] wr_data,
   input  logic                 rd_en,
   input  logic [ADDR_W-1:0]    rd_addr,
   output logic [DATA_SIZE-1:0] rd_data
);

   logic [DATA_SIZE-1:0] mem [MAIN_SIZE];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Only the output register is reset; array contents survive reset.
   always_ff @(posedge clk) begin
      if (reset)      rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fifo_param_sync.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty levels,
// occupancy count, read-valid strobe and sticky typed overflow/underflow report.
module fifo_param_sync
   import fifo_param_sync_pkg::*;
#(
   parameter  int DATA_SIZE = 8,
   parameter  int MAIN_SIZE = 8,
   localparam int CNT_W     = $clog2(MAIN_SIZE + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 write,
   input  logic [DATA_SIZE-1:0] data_in_push,
   input  logic                 read,
   input  logic [CNT_W-1:0]     th_full,
   input  logic [CNT_W-1:0]     th_empty,
   input  logic                 err_clr,
   output logic [DATA_SIZE-1:0] data_out_pop,
   output logic                 valid_out,
   output logic [CNT_W-1:0]     fifo_count,
   output logic                 fifo_empty,
   output logic                 fifo_full,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 fifo_pause,
   output logic                 fifo_error,
   output logic [ERR_W-1:0]     err_code
);

   localparam int               PTR_W = $clog2(MAIN_SIZE);
   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MAIN_SIZE);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;
   logic             ovf;
   logic             udf;
   err_code_t        err_next;

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == DEPTH);

   // A read on a full FIFO frees the slot the simultaneous write takes.
   assign push_ok = ~reset & write & (~fifo_full | read);
   assign pop_ok  = ~reset & read & ~fifo_empty;
   assign ovf     = write & fifo_full & ~read;
   assign udf     = read & fifo_empty;

   fifo_mem_dp #(
      .DATA_SIZE (DATA_SIZE),
      .MAIN_SIZE (MAIN_SIZE),
      .ADDR_W    (PTR_W)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push_ok),
      .wr_addr (wr_ptr),
      .wr_data (data_in_push),
      .rd_en   (pop_ok),
      .rd_addr (rd_ptr),
      .rd_data (data_out_pop)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         valid_out  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= PTR_W'(wrap_inc(32'(wr_ptr), MAIN_SIZE));
         if (pop_ok)  rd_ptr <= PTR_W'(wrap_inc(32'(rd_ptr), MAIN_SIZE));
         valid_out <= pop_ok;
         case ({push_ok, pop_ok})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: ;
         endcase
      end
   end

   // Clear first, then OR in new causes so a coincident error survives err_clr.
   always_comb begin
      err_next          = err_clr ? '0 : err_code;
      err_next[ERR_OVF] = err_next[ERR_OVF] | ovf;
      err_next[ERR_UDF] = err_next[ERR_UDF] | udf;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_code   <= '0;
         fifo_error <= 1'b0;
      end else begin
         err_code   <= err_next;
         fifo_error <= |err_next;
      end
   end

   // A threshold above the depth degenerates to "almost full only when full".
   assign almost_full  = (fifo_count >= th_full) | fifo_full;
   assign almost_empty = (fifo_count <= th_empty);
   assign fifo_pause   = almost_full | fifo_full;

endmodule

// File: tb/tb_fifo_param_sync.sv
// Self-checking bench for fifo_param_sync against a queue-based reference model.
module tb_fifo_param_sync;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          write = 1'b0;
   logic [DW-1:0] data_in_push = '0;
   logic          read = 1'b0;
   logic [CW-1:0] th_full = 4'd6;
   logic [CW-1:0] th_empty = 4'd2;
   logic          err_clr = 1'b0;
   logic [DW-1:0] data_out_pop;
   logic          valid_out;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty, fifo_full, almost_full, almost_empty, fifo_pause, fifo_error;
   logic [1:0]    err_code;

   always #5 clk = ~clk;

   fifo_param_sync #(.DATA_SIZE(DW), .MAIN_SIZE(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .write        (write),
      .data_in_push (data_in_push),
      .read         (read),
      .th_full      (th_full),
      .th_empty     (th_empty),
      .err_clr      (err_clr),
      .data_out_pop (data_out_pop),
      .valid_out    (valid_out),
      .fifo_count   (fifo_count),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .fifo_pause   (fifo_pause),
      .fifo_error   (fifo_error),
      .err_code     (err_code)
   );

   // reference model state
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout = '0;
   logic          m_valid = 1'b0;
   logic [1:0]    m_err = 2'b00;
   int            n_pass = 0;
   int            n_total = 0;

   task automatic drive(input logic rs, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic ec);
      bit m_full, m_empty;
      @(negedge clk);
      reset = rs; write = w; data_in_push = d; read = r; err_clr = ec;
      m_full  = (q.size() == DEPTH);
      m_empty = (q.size() == 0);
      @(posedge clk);
      if (rs) begin
         q.delete(); m_dout = '0; m_valid = 1'b0; m_err = 2'b00;
      end else begin
         m_valid = r && !m_empty;
         if (m_valid) m_dout = q.pop_front();
         if (w && (!m_full || r)) q.push_back(d);
         if (ec) m_err = 2'b00;
         if (w && m_full && !r) m_err[0] = 1'b1;
         if (r && m_empty) m_err[1] = 1'b1;
      end
      #1;
   endtask

   function automatic logic exp_af();
      return (q.size() >= int'(th_full)) || (q.size() == DEPTH);
   endfunction

   task automatic test_reset();
      drive(1, 0, 0, 0, 0);
      n_total++; if (fifo_empty !== 1'b1) $display("FAIL rst_empty got %b exp 1", fifo_empty); else n_pass++;
      n_total++; if (almost_empty !== 1'b1) $display("FAIL rst_aempty got %b exp 1", almost_empty); else n_pass++;
      n_total++; if (fifo_full !== 1'b0) $display("FAIL rst_full got %b exp 0", fifo_full); else n_pass++;
      n_total++; if (fifo_count !== 4'd0) $display("FAIL rst_count got %0d exp 0", fifo_count); else n_pass++;
      n_total++; if (valid_out !== 1'b0) $display("FAIL rst_valid got %b exp 0", valid_out); else n_pass++;
      n_total++; if (err_code !== 2'b00 || fifo_error !== 1'b0)
         $display("FAIL rst_err got %b/%b exp 00/0", err_code, fifo_error); else n_pass++;
      n_total++; if (data_out_pop !== 8'h00) $display("FAIL rst_dout got %h exp 00", data_out_pop); else n_pass++;
      n_total++; if (almost_full !== 1'b0 || fifo_pause !== 1'b0)
         $display("FAIL rst_af got %b/%b exp 0/0", almost_full, fifo_pause); else n_pass++;
      @(negedge clk); th_full = 4'd0; #1;
      n_total++; if (almost_full !== 1'b1 || fifo_pause !== 1'b1)
         $display("FAIL rst_af_th0 got %b/%b exp 1/1", almost_full, fifo_pause); else n_pass++;
      th_full = 4'd6;
   endtask

   task automatic test_fill_drain();
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 1, 8'(16 + i), 0, 0);
         n_total++; if (fifo_count !== 4'(i + 1)) $display("FAIL fill_count got %0d exp %0d", fifo_count, i + 1); else n_pass++;
         n_total++; if (fifo_full !== (i == DEPTH - 1)) $display("FAIL fill_full i=%0d got %b", i, fifo_full); else n_pass++;
         n_total++; if (almost_full !== (i + 1 >= 6) || fifo_pause !== (i + 1 >= 6))
            $display("FAIL fill_af i=%0d got %b/%b exp %b", i, almost_full, fifo_pause, (i + 1 >= 6)); else n_pass++;
         n_total++; if (almost_empty !== (i + 1 <= 2)) $display("FAIL fill_ae i=%0d got %b", i, almost_empty); else n_pass++;
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 1, 0);
         n_total++; if (valid_out !== 1'b1 || data_out_pop !== 8'(16 + i))
            $display("FAIL drain_data i=%0d got %b/%h exp 1/%h", i, valid_out, data_out_pop, 8'(16 + i)); else n_pass++;
         n_total++; if (fifo_count !== 4'(DEPTH - 1 - i)) $display("FAIL drain_count got %0d exp %0d", fifo_count, DEPTH - 1 - i); else n_pass++;
      end
      drive(0, 0, 0, 0, 0);
      n_total++; if (valid_out !== 1'b0 || data_out_pop !== 8'h17)
         $display("FAIL drain_hold got %b/%h exp 0/17", valid_out, data_out_pop); else n_pass++;
   endtask

   task automatic test_overflow();
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) drive(0, 1, 8'(16 + i), 0, 0);
      drive(0, 1, 8'hAA, 0, 0);
      n_total++; if (fifo_count !== 4'd8) $display("FAIL ovf_count got %0d exp 8", fifo_count); else n_pass++;
      n_total++; if (err_code !== 2'b01 || fifo_error !== 1'b1)
         $display("FAIL ovf_err got %b/%b exp 01/1", err_code, fifo_error); else n_pass++;
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 1, 0);
         n_total++; if (data_out_pop !== 8'(16 + i)) $display("FAIL ovf_data i=%0d got %h exp %h", i, data_out_pop, 8'(16 + i)); else n_pass++;
      end
      n_total++; if (fifo_empty !== 1'b1 || err_code !== 2'b01)
         $display("FAIL ovf_after got %b/%b exp 1/01", fifo_empty, err_code); else n_pass++;
   endtask

   task automatic test_underflow_clr();
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0);
      n_total++; if (err_code !== 2'b10 || fifo_error !== 1'b1 || valid_out !== 1'b0)
         $display("FAIL udf_err got %b/%b/%b exp 10/1/0", err_code, fifo_error, valid_out); else n_pass++;
      n_total++; if (data_out_pop !== m_dout) $display("FAIL udf_hold got %h exp %h", data_out_pop, m_dout); else n_pass++;
      drive(0, 0, 0, 0, 1);
      n_total++; if (err_code !== 2'b00 || fifo_error !== 1'b0)
         $display("FAIL udf_clr got %b/%b exp 00/0", err_code, fifo_error); else n_pass++;
      drive(0, 0, 0, 1, 1);
      n_total++; if (err_code !== 2'b10 || fifo_error !== 1'b1)
         $display("FAIL udf_clr_new got %b/%b exp 10/1", err_code, fifo_error); else n_pass++;
      drive(0, 1, 8'h77, 1, 1);
      n_total++; if (err_code !== 2'b10 || fifo_count !== 4'd1 || valid_out !== 1'b0)
         $display("FAIL udf_rw_empty got %b/%0d/%b exp 10/1/0", err_code, fifo_count, valid_out); else n_pass++;
   endtask

   task automatic test_full_rw();
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) drive(0, 1, 8'(16 + i), 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 1, 8'h55, 1, 0);
         n_total++; if (fifo_count !== 4'd8 || err_code !== 2'b00)
            $display("FAIL frw_count i=%0d got %0d/%b exp 8/00", i, fifo_count, err_code); else n_pass++;
         n_total++; if (valid_out !== 1'b1 || data_out_pop !== 8'(16 + i))
            $display("FAIL frw_data i=%0d got %b/%h exp 1/%h", i, valid_out, data_out_pop, 8'(16 + i)); else n_pass++;
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 1, 0);
         n_total++; if (data_out_pop !== 8'h55) $display("FAIL frw_tail i=%0d got %h exp 55", i, data_out_pop); else n_pass++;
      end
   endtask

   task automatic test_threshold();
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 8'(i), 0, 0);
      @(negedge clk); th_full = 4'd6; #1;
      n_total++; if (almost_full !== 1'b0) $display("FAIL th_af6 got %b exp 0", almost_full); else n_pass++;
      th_full = 4'd3; #1;
      n_total++; if (almost_full !== 1'b1 || fifo_pause !== 1'b1)
         $display("FAIL th_af3 got %b/%b exp 1/1", almost_full, fifo_pause); else n_pass++;
      th_empty = 4'd3; #1;
      n_total++; if (almost_empty !== 1'b1) $display("FAIL th_ae3 got %b exp 1", almost_empty); else n_pass++;
      th_empty = 4'd2; th_full = 4'd15; #1;
      n_total++; if (almost_empty !== 1'b0 || almost_full !== 1'b0)
         $display("FAIL th_big got %b/%b exp 0/0", almost_empty, almost_full); else n_pass++;
      for (int i = 0; i < 5; i++) drive(0, 1, 8'(i), 0, 0);
      n_total++; if (almost_full !== 1'b1 || fifo_full !== 1'b1)
         $display("FAIL th_big_full got %b/%b exp 1/1", almost_full, fifo_full); else n_pass++;
      th_full = 4'd6;
   endtask

   task automatic test_random();
      logic w, r, ec;
      drive(1, 0, 0, 0, 0);
      for (int c = 0; c < 600; c++) begin
         int wb;
         wb = ((c / 40) % 2 == 0) ? 70 : 30;
         if ($urandom_range(0, 15) == 0) th_full = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) th_empty = 4'($urandom_range(0, 15));
         w  = ($urandom_range(0, 99) < wb);
         r  = ($urandom_range(0, 99) < 100 - wb);
         ec = ($urandom_range(0, 19) == 0);
         drive(0, w, 8'($urandom), r, ec);
         n_total++; if (fifo_count !== 4'(q.size())) $display("FAIL rnd_count c=%0d got %0d exp %0d", c, fifo_count, q.size()); else n_pass++;
         n_total++; if (fifo_empty !== (q.size() == 0) || fifo_full !== (q.size() == DEPTH))
            $display("FAIL rnd_ef c=%0d got %b/%b size %0d", c, fifo_empty, fifo_full, q.size()); else n_pass++;
         n_total++; if (almost_full !== exp_af() || fifo_pause !== exp_af())
            $display("FAIL rnd_af c=%0d got %b/%b exp %b", c, almost_full, fifo_pause, exp_af()); else n_pass++;
         n_total++; if (almost_empty !== (q.size() <= int'(th_empty)))
            $display("FAIL rnd_ae c=%0d got %b size %0d th %0d", c, almost_empty, q.size(), th_empty); else n_pass++;
         n_total++; if (valid_out !== m_valid || data_out_pop !== m_dout)
            $display("FAIL rnd_data c=%0d got %b/%h exp %b/%h", c, valid_out, data_out_pop, m_valid, m_dout); else n_pass++;
         n_total++; if (err_code !== m_err || fifo_error !== (|m_err))
            $display("FAIL rnd_err c=%0d got %b/%b exp %b/%b", c, err_code, fifo_error, m_err, |m_err); else n_pass++;
      end
      th_full = 4'd6; th_empty = 4'd2;
   endtask

   task automatic test_midreset();
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) drive(0, 1, 8'($urandom), (i > 2), 0);
      drive(1, 1, 8'hEE, 1, 0);
      n_total++; if (fifo_count !== 4'd0 || fifo_empty !== 1'b1 || valid_out !== 1'b0)
         $display("FAIL mrst_state got %0d/%b/%b exp 0/1/0", fifo_count, fifo_empty, valid_out); else n_pass++;
      drive(0, 1, 8'h3C, 0, 0);
      drive(0, 0, 0, 1, 0);
      n_total++; if (valid_out !== 1'b1 || data_out_pop !== 8'h3C || fifo_count !== 4'd0)
         $display("FAIL mrst_data got %b/%h/%0d exp 1/3c/0", valid_out, data_out_pop, fifo_count); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow_clr();
      test_full_rw();
      test_threshold();
      test_random();
      test_midreset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
